// File: rtl/enc_pkg.sv
// Shared types and widths for the one-hot stream encoder.
package enc_pkg;

  localparam int unsigned VEC_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE,
    EMIT
  } state_e;

endpackage

// File: rtl/prio_enc8.sv
// 8-bit priority encoder: index of the lowest or highest set bit, plus any/single flags.
module prio_enc8
  import enc_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic             msb_first,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  // Scan so the winning bit is the last one assigned.
  always_comb begin
    idx = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if (msb_first) begin
        if (vec[i]) idx = IDX_W'(i);
      end else begin
        if (vec[VEC_W-1-i]) idx = IDX_W'(VEC_W - 1 - i);
      end
    end
  end

  // Exactly one bit set <=> non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    any    = |vec;
    single = any && ((vec & (vec - VEC_W'(1))) == '0);
  end

endmodule

// File: rtl/onehot_stream_encoder.sv
// Streams the binary index of every set bit of an accepted request vector, one per beat.
module onehot_stream_encoder
  import enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [CNT_W-1:0] out_count,
  output logic             zero_pulse
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_single;

  function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < VEC_W; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // Outputs come only from the pending mask, so there is no path from the inputs.
  prio_enc8 u_prio (
    .vec       (pending_q),
    .msb_first (!LSB_FIRST),
    .idx       (enc_idx),
    .any       (enc_any),
    .single    (enc_single)
  );

  // State, pending mask, popcount and zero pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state: accept in IDLE, retire one pending bit per completed beat in EMIT.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    zero_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_vec;
          count_d   = popcount(in_vec);
          if (in_vec != '0) begin
            state_d = EMIT;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready && enc_any) begin
          pending_d = pending_q & ~(VEC_W'(1) << enc_idx);
          if (enc_single) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == EMIT);
    out_idx    = enc_idx;
    out_last   = enc_single;
    out_count  = count_q;
    zero_pulse = zero_q;
  end

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Scoreboard bench: stimulus pushes expected beats, per-instance monitors pop and compare.
module tb_onehot_stream_encoder;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } beat_t;

  logic clk;
  logic rst_n;

  // Instance A: LSB first.
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_zero;
  logic [7:0] a_in_vec;
  logic [2:0] a_out_idx;
  logic [3:0] a_out_count;

  // Instance B: MSB first.
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_zero;
  logic [7:0] b_in_vec;
  logic [2:0] b_out_idx;
  logic [3:0] b_out_count;

  beat_t qa[$];
  beat_t qb[$];

  int checks = 0;
  int errors = 0;

  onehot_stream_encoder #(.LSB_FIRST(1'b1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_vec     (a_in_vec),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_idx    (a_out_idx),
    .out_last   (a_out_last),
    .out_count  (a_out_count),
    .zero_pulse (a_zero)
  );

  onehot_stream_encoder #(.LSB_FIRST(1'b0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_vec     (b_in_vec),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_idx    (b_out_idx),
    .out_last   (b_out_last),
    .out_count  (b_out_count),
    .zero_pulse (b_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_beat: got idx %0d with empty scoreboard", a_out_idx);
      end else begin
        beat_t e;
        e = qa.pop_front();
        check("a_idx", {5'd0, a_out_idx}, {5'd0, e.idx});
        check("a_last", {7'd0, a_out_last}, {7'd0, e.last});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_beat: got idx %0d with empty scoreboard", b_out_idx);
      end else begin
        beat_t e;
        e = qb.pop_front();
        check("b_idx", {5'd0, b_out_idx}, {5'd0, e.idx});
        check("b_last", {7'd0, b_out_last}, {7'd0, e.last});
      end
    end
  end

  // Offer a vector on A; returns #1 after the accepting edge.
  task automatic send_a(input logic [7:0] vec);
    int n = 0;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!a_in_ready) begin
      checks++;
      errors++;
      $display("FAIL a_accept_timeout: in_ready got 0 expected 1");
    end
    a_in_valid = 1'b1;
    a_in_vec   = vec;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_vec   = 8'h5A;
  endtask

  task automatic send_b(input logic [7:0] vec);
    int n = 0;
    while (!b_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!b_in_ready) begin
      checks++;
      errors++;
      $display("FAIL b_accept_timeout: in_ready got 0 expected 1");
    end
    b_in_valid = 1'b1;
    b_in_vec   = vec;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_vec   = 8'hA5;
  endtask

  // Wait, bounded, for both scoreboards to empty.
  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending beats got %0d expected 0", name, qa.size() + qb.size());
      qa.delete();
      qb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_vec    = 8'h00;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_vec    = 8'h00;
    b_out_ready = 1'b1;

    // Reset then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {7'd0, a_in_ready}, 8'd1);
    check("rst_out_valid", {7'd0, a_out_valid}, 8'd0);
    check("rst_out_count", {4'd0, a_out_count}, 8'd0);
    check("rst_zero_pulse", {7'd0, a_zero}, 8'd0);
    check("rst_out_idx", {5'd0, a_out_idx}, 8'd0);
    check("rst_out_last", {7'd0, a_out_last}, 8'd0);

    // Multi-bit vector, no stall: indices 1,2,5,7.
    qa.push_back('{idx: 3'd1, last: 1'b0});
    qa.push_back('{idx: 3'd2, last: 1'b0});
    qa.push_back('{idx: 3'd5, last: 1'b0});
    qa.push_back('{idx: 3'd7, last: 1'b1});
    send_a(8'b1010_0110);
    check("multi_count", {4'd0, a_out_count}, 8'd4);
    check("multi_valid_latency", {7'd0, a_out_valid}, 8'd1);
    check("multi_in_ready_busy", {7'd0, a_in_ready}, 8'd0);
    repeat (5) @(negedge clk);
    check("multi_in_ready_after", {7'd0, a_in_ready}, 8'd1);
    check("multi_valid_after", {7'd0, a_out_valid}, 8'd0);
    check("multi_queue_empty", 8'(qa.size()), 8'd0);
    @(posedge clk); #1;

    // Backpressure on 0x81.
    a_out_ready = 1'b0;
    qa.push_back('{idx: 3'd0, last: 1'b0});
    qa.push_back('{idx: 3'd7, last: 1'b1});
    send_a(8'b1000_0001);
    check("bp_count", {4'd0, a_out_count}, 8'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {7'd0, a_out_valid}, 8'd1);
      check("bp_idx_stable", {5'd0, a_out_idx}, 8'd0);
      check("bp_last_stable", {7'd0, a_out_last}, 8'd0);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    drain("bp");

    // Zero vector.
    send_a(8'h00);
    check("zero_pulse_hi", {7'd0, a_zero}, 8'd1);
    check("zero_count", {4'd0, a_out_count}, 8'd0);
    check("zero_no_valid", {7'd0, a_out_valid}, 8'd0);
    check("zero_in_ready", {7'd0, a_in_ready}, 8'd1);
    @(posedge clk); #1;
    check("zero_pulse_lo", {7'd0, a_zero}, 8'd0);
    check("zero_no_valid2", {7'd0, a_out_valid}, 8'd0);

    // MSB-first full vector on B.
    for (int i = 7; i >= 0; i--) begin
      qb.push_back('{idx: 3'(i), last: (i == 0)});
    end
    send_b(8'hFF);
    check("msb_count", {4'd0, b_out_count}, 8'd8);
    drain("msb");
    check("msb_idle", {7'd0, b_in_ready}, 8'd1);

    // Reset mid-operation on 0x3C after one beat.
    qa.push_back('{idx: 3'd2, last: 1'b0});
    send_a(8'h3C);
    check("mid_count", {4'd0, a_out_count}, 8'd4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_async_valid", {7'd0, a_out_valid}, 8'd0);
    check("mid_beat_done", 8'(qa.size()), 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_in_ready", {7'd0, a_in_ready}, 8'd1);
    check("mid_out_valid", {7'd0, a_out_valid}, 8'd0);
    check("mid_out_count", {4'd0, a_out_count}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_no_residual", {7'd0, a_out_valid}, 8'd0);
    qa.push_back('{idx: 3'd4, last: 1'b1});
    send_a(8'h10);
    check("post_count", {4'd0, a_out_count}, 8'd1);
    drain("post");
    repeat (3) @(posedge clk);
    #1;
    check("post_idle", {7'd0, a_out_valid}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
